// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters with sync, blank and frame markers.
// All markers are registered from the next counter values so they line up with DrawX/DrawY.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_frameStart;
  logic [15:0] r_frameCount;

  logic        w_xWrap;
  logic        w_yWrap;
  logic [9:0]  w_nextX;
  logic [9:0]  w_nextY;

  always_comb begin
    w_xWrap = (r_x == H_LAST);
    w_yWrap = w_xWrap && (r_y == V_LAST);
    w_nextX = w_xWrap ? 10'd0 : r_x + 10'd1;
    if (w_yWrap) begin
      w_nextY = 10'd0;
    end else if (w_xWrap) begin
      w_nextY = r_y + 10'd1;
    end else begin
      w_nextY = r_y;
    end
  end

  // A frame wraps exactly when the next position is (0,0), so frame_start and the counter share w_yWrap.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_blank      <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameCount <= 16'd0;
    end else begin
      r_x          <= w_nextX;
      r_y          <= w_nextY;
      r_hs         <= !((w_nextX >= HS_FIRST) && (w_nextX <= HS_LAST));
      r_vs         <= !((w_nextY >= VS_FIRST) && (w_nextY <= VS_LAST));
      r_blank      <= (w_nextX < H_VIS) && (w_nextY < V_VIS);
      r_frameStart <= w_yWrap;
      if (w_yWrap) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign frame_start = r_frameStart;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance covers whole frames, vsync and wraps,
// a default-timing instance covers reset release and the 640x480 horizontal line.
module tb_vga_sync_gen;

  // Shrunken timing: 20 clocks per line, 13 lines per frame.
  localparam int S_HA = 10, S_HFP = 2, S_HS = 3, S_HBP = 5;
  localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_FRAME_CYCLES = 260;
  localparam int S_BLANK_CYCLES = 60;
  localparam int S_VSLOW_CYCLES = 40;

  logic        vga_clk = 1'b0;
  logic        rstS = 1'b1;
  logic        rstD = 1'b1;

  logic        hsS, vsS, blankS, syncS, fsS;
  logic [9:0]  xS, yS;
  logic [15:0] fcS;
  logic        hsD, vsD, blankD, syncD, fsD;
  logic [9:0]  xD, yD;
  logic [15:0] fcD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    int          cycles;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[17];

  always #5 vga_clk = ~vga_clk;

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dutS (
    .vga_clk(vga_clk), .reset(rstS), .hs(hsS), .vs(vsS), .blank(blankS), .sync(syncS),
    .DrawX(xS), .DrawY(yS), .frame_start(fsS), .frame_count(fcS)
  );

  vga_sync_gen dutD (
    .vga_clk(vga_clk), .reset(rstD), .hs(hsD), .vs(vsD), .blank(blankD), .sync(syncD),
    .DrawX(xD), .DrawY(yD), .frame_start(fsD), .frame_count(fcD)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic applyStimulus(input logic rst, input int cycles);
    rstS = rst;
    waitCycles(cycles);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int cnt, blanks, vsLow, badVsEdge, hsLow;
    logic found, prevVs, expHs;
    logic [15:0] fcStart;
    logic [9:0] ex, ey;

    // Positions counted from reset release: p edges later DrawX = p%20, DrawY = p/20.
    vecs[0]  = '{1'b1, 5,   10'd0,  10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1,   10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 8,   10'd9,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1,   10'd10, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1,   10'd11, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1,   10'd12, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 2,   10'd14, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1,   10'd15, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 4,   10'd19, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 1,   10'd0,  10'd1,  1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 139, 10'd19, 10'd7,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 1,   10'd0,  10'd8,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[12] = '{1'b0, 39,  10'd19, 10'd9,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[13] = '{1'b0, 1,   10'd0,  10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[14] = '{1'b0, 59,  10'd19, 10'd12, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[15] = '{1'b0, 1,   10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[16] = '{1'b0, 1,   10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 16'd1};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i),
                  {xS, yS, hsS, vsS, blankS, fsS, syncS, fcS},
                  {vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].fs, 1'b0, vecs[i].fc});
    end

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      waitCycles(1);
      if (fsS) found = 1'b1;
    end
    checkOutput("alignFrame", found, 1);

    // Whole frames: length, visible count, vsync width and vsync edges only at DrawX=0.
    for (int f = 0; f < 3; f++) begin
      fcStart = fcS;
      cnt = 0; blanks = 0; vsLow = 0; badVsEdge = 0; found = 1'b0;
      while (!found && cnt < 1000) begin
        if (blankS) blanks++;
        if (!vsS) vsLow++;
        if (syncS !== 1'b0) badVsEdge++;
        prevVs = vsS;
        waitCycles(1);
        cnt++;
        if (vsS != prevVs && xS != 10'd0) badVsEdge++;
        if (fsS) found = 1'b1;
      end
      checkOutput($sformatf("frame%0d_len", f), cnt, S_FRAME_CYCLES);
      checkOutput($sformatf("frame%0d_blank", f), blanks, S_BLANK_CYCLES);
      checkOutput($sformatf("frame%0d_vsLow", f), vsLow, S_VSLOW_CYCLES);
      checkOutput($sformatf("frame%0d_vsEdge", f), badVsEdge, 0);
      checkOutput($sformatf("frame%0d_count", f), fcS, 16'(fcStart + 16'd1));
    end

    force dutS.r_frameCount = 16'hFFFF;
    waitCycles(1);
    release dutS.r_frameCount;
    waitCycles(1);
    checkOutput("preload", fcS, 16'hFFFF);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      waitCycles(1);
      if (fsS) found = 1'b1;
    end
    checkOutput("wrapPulse", found, 1);
    checkOutput("wrapCount", fcS, 16'h0000);

    // Reset while both syncs are low must drop them immediately.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      waitCycles(1);
      if (xS == 10'd13 && yS == 10'd9) found = 1'b1;
    end
    checkOutput("midPos", found, 1);
    checkOutput("midSyncLow", {hsS, vsS}, 2'b00);
    applyStimulus(1'b1, 1);
    checkOutput("midReset", {xS, yS, hsS, vsS, blankS, fsS, syncS, fcS},
                {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 1);
    checkOutput("midRelease", {xS, yS, blankS, fsS}, {10'd1, 10'd0, 1'b1, 1'b0});

    checkOutput("dReset", {xD, yD, hsD, vsD, blankD, fsD, syncD, fcD},
                {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    rstD = 1'b0;
    waitCycles(1);
    checkOutput("dRelease", {xD, yD, hsD, vsD, blankD}, {10'd1, 10'd0, 1'b1, 1'b1, 1'b1});
    waitCycles(7998);
    checkOutput("dLine9End", {xD, yD}, {10'd799, 10'd9});

    // Line 10 of the 640x480 timing, plus the first two pixels of line 11.
    hsLow = 0;
    for (int i = 0; i < 802; i++) begin
      waitCycles(1);
      ex = (i < 800) ? 10'(i) : 10'(i - 800);
      ey = (i < 800) ? 10'd10 : 10'd11;
      expHs = !((ex >= 10'd656) && (ex <= 10'd751));
      if (!hsD && i < 800) hsLow++;
      checkOutput($sformatf("line10_x%0d", ex), {xD, yD, hsD, vsD, blankD},
                  {ex, ey, expHs, 1'b1, (ex < 10'd640)});
    end
    checkOutput("line10_hsWidth", hsLow, 96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
